regfile_decoded: RTL and testbench

Parametrised register file for the MIPS single-cycle datapath with an integrated write-enable decoder, hardwired zero register and a sequenced bulk-clear engine. It sits between the control unit (reg_write), the instruction decode fields (rs/rt/rd) and the ALU/writeback mux, replacing the fixed 32-entry decoder-plus-registers arrangement. It generalises register count and width, adds a multi-cycle clear sequence with a stall indication and, optionally, same-cycle write-to-read bypass.

---
 rtl/regfile_decoded_pkg.sv | 12 +
 rtl/regfile_decoded_if.sv | 29 ++
 rtl/regfile_decoded_wr_en_decoder.sv | 19 +
 rtl/regfile_decoded.sv | 108 ++++++++++
 tb/tb_regfile_decoded.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_decoded_pkg.sv
// Shared types and defaults for the decoded MIPS register file.
package mips_rf_pkg;

    localparam int RF_NUM_REGS_DEF = 32;
    localparam int RF_DATA_W_DEF   = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_decoded_if.sv
// Datapath-side bundle of the register file: clear, write and read ports.
interface regfile_decoded_if #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic                clear_req;
    logic                busy;
    logic                reg_write;
    logic [ADDR_W-1:0]   write_reg;
    logic [DATA_W-1:0]   write_data;
    logic [ADDR_W-1:0]   read_reg1;
    logic [ADDR_W-1:0]   read_reg2;
    logic [DATA_W-1:0]   read_data1;
    logic [DATA_W-1:0]   read_data2;
    logic [NUM_REGS-1:0] write_en_vec;

    modport master (
        output clear_req, reg_write, write_reg, write_data,
        output read_reg1, read_reg2,
        input  busy, read_data1, read_data2, write_en_vec
    );

    modport slave (
        input  clear_req, reg_write, write_reg, write_data,
        input  read_reg1, read_reg2,
        output busy, read_data1, read_data2, write_en_vec
    );
endinterface

// File: rtl/regfile_decoded_wr_en_decoder.sv
// Index-to-one-hot write enable decoder with enable gate and
// optional masking of the hardwired zero register.
module wr_en_decoder #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_vec
);
    always_comb begin
        o_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            o_vec[i] = i_en && (i_addr == ADDR_W'(i))
                       && !(ZERO_REG != 0 && i == 0);
        end
    end
endmodule

// File: rtl/regfile_decoded.sv
// Register file with decoded write enables and a sequenced bulk clear.
// Define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_decoded
    import mips_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS_DEF,
    parameter int DATA_W   = RF_DATA_W_DEF,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    regfile_decoded_if.slave bus
);
    rf_state_e           r_state;
    rf_state_e           w_next_state;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [ADDR_W-1:0]   w_next_idx;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                w_busy;
    logic [NUM_REGS-1:0] w_we;
    logic [ADDR_W-1:0]   w_raddr [2];
    logic [DATA_W-1:0]   w_rdata [2];

    assign w_busy = (r_state == RF_CLEAR);

    wr_en_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_dec (
        .i_en   (bus.reg_write && !w_busy),
        .i_addr (bus.write_reg),
        .o_vec  (w_we)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RF_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_idx;
        end
    end

    // clear_req is only looked at in IDLE, so it cannot restart a clear
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_clr_idx;
        unique case (r_state)
            RF_IDLE: begin
                if (bus.clear_req) begin
                    w_next_state = RF_CLEAR;
                    w_next_idx   = '0;
                end
            end
            RF_CLEAR: begin
                w_next_idx = r_clr_idx + 1'b1;
                if (r_clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                    w_next_state = RF_IDLE;
                    w_next_idx   = '0;
                end
            end
            default: begin
                w_next_state = RF_IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset) begin
                r_regs[i] <= '0;
            end else if (w_busy && r_clr_idx == ADDR_W'(i)) begin
                r_regs[i] <= '0;
            end else if (w_we[i]) begin
                r_regs[i] <= bus.write_data;
            end
        end
    end

    assign w_raddr[0] = bus.read_reg1;
    assign w_raddr[1] = bus.read_reg2;

    // w_we is nonzero only for a legal, unmasked write, so forwarding on it
    // keeps the zero-register and range rules ahead of the bypass
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = '0;
            if (int'(w_raddr[p]) < NUM_REGS
                && !(ZERO_REG != 0 && w_raddr[p] == '0)) begin
                w_rdata[p] = r_regs[w_raddr[p]];
            end
`ifdef RF_BYPASS_EN
            if ((|w_we) && bus.write_reg == w_raddr[p]) begin
                w_rdata[p] = bus.write_data;
            end
`endif
        end
    end

    assign bus.busy         = w_busy;
    assign bus.write_en_vec = w_we;
    assign bus.read_data1   = w_rdata[0];
    assign bus.read_data2   = w_rdata[1];
endmodule

// File: tb/tb_regfile_decoded.sv
// Self-checking bench for regfile_decoded (32/zero-reg, 32/no zero-reg, 24 deep).
module tb_regfile_decoded;
    import mips_rf_pkg::*;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_decoded_if #(.NUM_REGS(32), .DATA_W(32)) bm();
    regfile_decoded_if #(.NUM_REGS(32), .DATA_W(32)) bz();
    regfile_decoded_if #(.NUM_REGS(24), .DATA_W(32)) bs();

    regfile_decoded #(.NUM_REGS(32), .DATA_W(32), .ZERO_REG(1))
        u_main (.clk(clk), .reset(reset), .bus(bm));
    regfile_decoded #(.NUM_REGS(32), .DATA_W(32), .ZERO_REG(0))
        u_z0 (.clk(clk), .reset(reset), .bus(bz));
    regfile_decoded #(.NUM_REGS(24), .DATA_W(32), .ZERO_REG(1))
        u_24 (.clk(clk), .reset(reset), .bus(bs));

    int checks = 0;
    int errors = 0;
    logic [31:0] m [32];

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] ewev;
        logic [31:0] erd1;
        logic [31:0] erd2;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] r,
        input logic we, input logic [4:0] wr, input logic [31:0] wd);
        logic [31:0] v;
        v = (r == 5'd0) ? 32'h0 : m[r];
        if (BYP && we && wr == r && r != 5'd0) v = wd;
        return v;
    endfunction

    function automatic logic [31:0] exp_wev(input logic we,
                                            input logic [4:0] wr);
        return (we && wr != 5'd0) ? (32'h1 << wr) : 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [4:0]  wr, r1, r2;
        logic [31:0] wd;
        int          wait_n;

        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd0,
                   32'h0000_0020, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 5'd0,  32'h0000_1234, 5'd5, 5'd0,
                   32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd3,  32'h0000_0001, 5'd0, 5'd5,
                   32'h0000_0008, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd9,  32'h0000_FFFF, 5'd3, 5'd9,
                   32'h0, 32'h1, 32'h0};
        tbl[4] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd3, 5'd9,
                   32'h8000_0000, 32'h1, 32'h0};
        tbl[5] = '{1'b0, 5'd0,  32'h0, 5'd31, 5'd3,
                   32'h0, 32'hCAFEF00D, 32'h1};

        bm.clear_req = 0; bm.reg_write = 0; bm.write_reg = 0;
        bm.write_data = 0; bm.read_reg1 = 0; bm.read_reg2 = 0;
        bz.clear_req = 0; bz.reg_write = 0; bz.write_reg = 0;
        bz.write_data = 0; bz.read_reg1 = 0; bz.read_reg2 = 0;
        bs.clear_req = 0; bs.reg_write = 0; bs.write_reg = 0;
        bs.write_data = 0; bs.read_reg1 = 0; bs.read_reg2 = 0;
        for (int k = 0; k < 32; k++) m[k] = 32'h0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bm.read_reg1 = 5'd5; bm.read_reg2 = 5'd31;
        bs.read_reg1 = 5'd23; bs.read_reg2 = 5'd28;
        #4;
        chk("rst_busy", 32'(bm.busy), 32'h0);
        chk("rst_rd1", bm.read_data1, 32'h0);
        chk("rst_rd2", bm.read_data2, 32'h0);
        chk("rst_wev", bm.write_en_vec, 32'h0);
        chk("rst_n24_rd23", bs.read_data1, 32'h0);
        chk("rst_n24_rd28", bs.read_data2, 32'h0);
        tick();

        for (int i = 0; i < 6; i++) begin
            bm.reg_write = tbl[i].we; bm.write_reg = tbl[i].wr;
            bm.write_data = tbl[i].wd;
            bm.read_reg1 = tbl[i].r1; bm.read_reg2 = tbl[i].r2;
            #4;
            chk($sformatf("vec%0d_wev", i), bm.write_en_vec, tbl[i].ewev);
            chk($sformatf("vec%0d_rd1", i), bm.read_data1, tbl[i].erd1);
            chk($sformatf("vec%0d_rd2", i), bm.read_data2, tbl[i].erd2);
            if (tbl[i].we && tbl[i].wr != 5'd0) m[tbl[i].wr] = tbl[i].wd;
            tick();
        end

        bm.reg_write = 1; bm.write_reg = 5'd3;
        bm.write_data = 32'hA5A5A5A5; bm.read_reg1 = 5'd3;
        #4;
        chk("bypass_same_cycle", bm.read_data1,
            BYP ? 32'hA5A5A5A5 : 32'h1);
        tick();
        bm.reg_write = 0;
        m[3] = 32'hA5A5A5A5;
        #4;
        chk("write_next_cycle", bm.read_data1, 32'hA5A5A5A5);
        tick();

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = 5'($urandom_range(0, 31));
            r2 = 5'($urandom_range(0, 31));
            bm.reg_write = we; bm.write_reg = wr; bm.write_data = wd;
            bm.read_reg1 = r1; bm.read_reg2 = r2;
            #4;
            chk("rnd_wev", bm.write_en_vec, exp_wev(we, wr));
            chk("rnd_rd1", bm.read_data1, exp_rd(r1, we, wr, wd));
            chk("rnd_rd2", bm.read_data2, exp_rd(r2, we, wr, wd));
            tick();
            if (we && wr != 5'd0) m[wr] = wd;
        end

        for (int k = 1; k < 32; k++) begin
            bm.reg_write = 1; bm.write_reg = 5'(k); bm.write_data = 32'(k);
            tick();
        end
        bm.reg_write = 0;

        bm.clear_req = 1;
        tick();
        for (int j = 0; j < 32; j++) begin
            bm.clear_req = (j < 2);
            bm.read_reg1 = (j == 0) ? 5'd0 : 5'(j - 1);
            bm.read_reg2 = 5'(j);
            bm.reg_write = (j == 3 || j == 10);
            bm.write_reg = 5'd7; bm.write_data = 32'h77;
            #4;
            chk("clr_busy", 32'(bm.busy), 32'h1);
            chk("clr_done_reg", bm.read_data1, 32'h0);
            chk("clr_pending_reg", bm.read_data2, 32'(j));
            chk("clr_wev_masked", bm.write_en_vec, 32'h0);
            tick();
        end
        bm.reg_write = 0; bm.read_reg1 = 5'd7; bm.read_reg2 = 5'd31;
        #4;
        chk("clr_end_busy", 32'(bm.busy), 32'h0);
        chk("clr_reg7_dropped", bm.read_data1, 32'h0);
        chk("clr_reg31", bm.read_data2, 32'h0);
        tick();
        for (int k = 0; k < 32; k++) m[k] = 32'h0;
        for (int k = 0; k < 32; k++) begin
            bm.read_reg1 = 5'(k);
            #4;
            chk("clr_all_zero", bm.read_data1, m[k]);
            tick();
        end

        bm.reg_write = 1; bm.write_reg = 5'd20; bm.write_data = 32'h2020;
        tick();
        bm.reg_write = 0; bm.clear_req = 1;
        tick();
        bm.clear_req = 0;
        repeat (10) tick();
        reset = 1;
        #4;
        chk("midclr_busy", 32'(bm.busy), 32'h1);
        tick();
        reset = 0;
        bm.read_reg1 = 5'd20; bm.read_reg2 = 5'd31;
        #4;
        chk("abort_busy", 32'(bm.busy), 32'h0);
        chk("abort_reg20", bm.read_data1, 32'h0);
        chk("abort_reg31", bm.read_data2, 32'h0);
        tick();

        bm.clear_req = 1; bm.reg_write = 1; bm.write_reg = 5'd2;
        bm.write_data = 32'h22; bm.read_reg1 = 5'd2;
        tick();
        bm.clear_req = 0; bm.reg_write = 0;
        #4;
        chk("reaccept_busy", 32'(bm.busy), 32'h1);
        chk("wr_with_clear", bm.read_data1, 32'h22);
        tick();
        tick();
        #4;
        chk("wr_with_clear_hold", bm.read_data1, 32'h22);
        tick();
        #4;
        chk("wr_with_clear_gone", bm.read_data1, 32'h0);
        wait_n = 0;
        while (bm.busy && wait_n < 40) begin
            tick();
            wait_n++;
        end
        chk("clear_terminates", 32'(bm.busy), 32'h0);

        bz.reg_write = 1; bz.write_reg = 5'd0;
        bz.write_data = 32'h1234; bz.read_reg1 = 5'd0;
        #4;
        chk("z0_wev", bz.write_en_vec, 32'h1);
        chk("z0_same_cycle", bz.read_data1, BYP ? 32'h1234 : 32'h0);
        tick();
        bz.reg_write = 0;
        #4;
        chk("z0_read", bz.read_data1, 32'h1234);
        tick();

        bs.reg_write = 1; bs.write_reg = 5'd28;
        bs.write_data = 32'hBAD; bs.read_reg1 = 5'd28;
        #4;
        chk("n24_wev_oob", 32'(bs.write_en_vec), 32'h0);
        chk("n24_rd_oob", bs.read_data1, 32'h0);
        tick();
        bs.write_reg = 5'd23; bs.write_data = 32'h2323;
        #4;
        chk("n24_wev23", 32'(bs.write_en_vec), 32'h0080_0000);
        tick();
        bs.reg_write = 0; bs.read_reg2 = 5'd23;
        #4;
        chk("n24_rd_oob_after", bs.read_data1, 32'h0);
        chk("n24_rd23", bs.read_data2, 32'h2323);
        tick();
        bs.read_reg1 = 5'd4; bs.read_reg2 = 5'd12;
        #4;
        chk("n24_alias4", bs.read_data1, 32'h0);
        chk("n24_alias12", bs.read_data2, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
